// File: rtl/rgb565_frame_reader.sv
// rgb565_frame_reader
//   Scans an RGB565 frame memory from address 0 to H_ACTIVE*V_ACTIVE-1 on a
//   start request. Each word is expanded to RGB888 by MSB replication and
//   streamed out over a valid/ready interface. A small first-word-fall-through
//   FIFO absorbs the fixed memory read latency, and reads are only issued when
//   the FIFO is guaranteed to have room, so backpressure never drops a pixel.
//
// Ports
//   iClk, iRst_n    clock, synchronous active-low reset
//   i_Clk_en        clock enable; when low all state holds and nothing transfers
//   i_start         frame start request, only looked at in IDLE
//   o_rd_addr/o_rd_en/i_rd_data   frame memory read port, RD_LAT cycles latency
//   o_data_rgb888, o_valid, i_ready, o_sof, o_eol   pixel stream
//   o_busy          frame in progress (READ or DRAIN)
//   o_frame_done    one-cycle pulse once the last pixel has been accepted
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_IDLE  | waiting for i_start, address at 0
// S_READ  | issuing reads as FIFO credit allows
// S_DRAIN | all reads issued; waiting for pipeline and FIFO to empty
// S_DONE  | o_frame_done asserted for one enabled cycle
module rgb565_frame_reader #(
  parameter int H_ACTIVE   = 480,
  parameter int V_ACTIVE   = 272,
  parameter int ADDR_WIDTH = 17,
  parameter int RD_LAT     = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  iClk,
  input  logic                  iRst_n,
  input  logic                  i_Clk_en,
  input  logic                  i_start,
  output logic [ADDR_WIDTH-1:0] o_rd_addr,
  output logic                  o_rd_en,
  input  logic [15:0]           i_rd_data,
  output logic [23:0]           o_data_rgb888,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic                  o_sof,
  output logic                  o_eol,
  output logic                  o_busy,
  output logic                  o_frame_done
);

  localparam int MEM_DEPTH = H_ACTIVE * V_ACTIVE;
  localparam int PW        = $clog2(FIFO_DEPTH);
  localparam int CW        = $clog2(FIFO_DEPTH + RD_LAT + 1);
  localparam int XW        = $clog2(H_ACTIVE + 1);
  localparam int YW        = $clog2(V_ACTIVE + 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEM_DEPTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [RD_LAT-1:0]     vld_sr_q, vld_sr_d;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [XW-1:0]         x_q, x_d;
  logic [YW-1:0]         y_q, y_d;
  logic [15:0]           fifo_q [FIFO_DEPTH];

  logic [CW-1:0]         inflight;
  logic                  issue, push, pop;
  logic [15:0]           head;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LAT; i++) inflight = inflight + CW'(vld_sr_q[i]);
  end

  // Credit uses registered occupancy only: a pop in the same cycle does not
  // free a slot until the next cycle, which keeps the check off the i_ready path.
  assign issue = i_Clk_en && (state_q == S_READ) &&
                 ((count_q + inflight) < CW'(FIFO_DEPTH));
  assign push  = vld_sr_q[RD_LAT-1];
  assign pop   = (count_q != '0) && i_ready && i_Clk_en;

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q + CW'(push) - CW'(pop);
    x_d      = x_q;
    y_d      = y_q;
    vld_sr_d = vld_sr_q << 1;
    vld_sr_d[0] = issue;

    if (issue) addr_d = (addr_q == LAST_ADDR) ? '0 : addr_q + ADDR_WIDTH'(1);

    if (pop) begin
      if (x_q == XW'(H_ACTIVE - 1)) begin
        x_d = '0;
        y_d = (y_q == YW'(V_ACTIVE - 1)) ? '0 : y_q + YW'(1);
      end else begin
        x_d = x_q + XW'(1);
      end
    end

    unique case (state_q)
      S_IDLE: begin
        if (i_start) begin
          state_d = S_READ;
          addr_d  = '0;
        end
      end
      S_READ: begin
        if (issue && (addr_q == LAST_ADDR)) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if ((vld_sr_d == '0) && (count_d == '0)) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      vld_sr_q <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      x_q      <= '0;
      y_q      <= '0;
    end else if (i_Clk_en) begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      vld_sr_q <= vld_sr_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      x_q      <= x_d;
      y_q      <= y_d;
    end
  end

  // Storage needs no reset; occupancy is tracked by count_q.
  always_ff @(posedge iClk) begin
    if (iRst_n && i_Clk_en && push) fifo_q[wr_ptr_q] <= i_rd_data;
  end

  assign head          = fifo_q[rd_ptr_q];
  assign o_valid       = (count_q != '0);
  assign o_data_rgb888 = o_valid ? {head[15:11], head[15:13],
                                    head[10:5],  head[10:9],
                                    head[4:0],   head[4:2]} : 24'h0;
  assign o_sof         = o_valid && (x_q == '0) && (y_q == '0);
  assign o_eol         = o_valid && (x_q == XW'(H_ACTIVE - 1));
  assign o_rd_addr     = addr_q;
  assign o_rd_en       = issue;
  assign o_busy        = (state_q == S_READ) || (state_q == S_DRAIN);
  assign o_frame_done  = (state_q == S_DONE);

  a_no_overflow: assert property (@(posedge iClk) disable iff (!iRst_n)
    !(i_Clk_en && push && !pop && (count_q == CW'(FIFO_DEPTH))));

endmodule

// File: tb/tb_rgb565_frame_reader.sv
module tb_rgb565_frame_reader;
  localparam int H   = 8;
  localparam int V   = 4;
  localparam int MEM = H * V;
  localparam int AW  = 5;
  localparam int LAT = 3;
  localparam int FD  = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clk_en = 1'b1;
  logic          start = 1'b0;
  logic          ready = 1'b1;
  logic [AW-1:0] rd_addr;
  logic          rd_en;
  logic [15:0]   rd_data;
  logic [23:0]   data;
  logic          valid, sof, eol, busy, frame_done;

  always #5 clk = ~clk;

  rgb565_frame_reader #(
    .H_ACTIVE(H), .V_ACTIVE(V), .ADDR_WIDTH(AW), .RD_LAT(LAT), .FIFO_DEPTH(FD)
  ) dut (
    .iClk(clk), .iRst_n(rst_n), .i_Clk_en(clk_en), .i_start(start),
    .o_rd_addr(rd_addr), .o_rd_en(rd_en), .i_rd_data(rd_data),
    .o_data_rgb888(data), .o_valid(valid), .i_ready(ready),
    .o_sof(sof), .o_eol(eol), .o_busy(busy), .o_frame_done(frame_done)
  );

  // Frame memory with an RD_LAT-deep enabled read pipeline. It keeps running
  // through reset so stale in-flight data still shows up on rd_data.
  logic [15:0] mem  [MEM];
  logic [15:0] pipe [LAT];
  always @(posedge clk) begin
    if (clk_en) begin
      for (int i = LAT - 1; i > 0; i--) pipe[i] <= pipe[i-1];
      pipe[0] <= rd_en ? mem[rd_addr] : 16'hDEAD;
    end
  end
  assign rd_data = pipe[LAT-1];

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  function automatic logic [23:0] ref_px(input logic [15:0] w);
    int r, g, b;
    r = int'(w) >> 11;
    g = (int'(w) >> 5) & 63;
    b = int'(w) & 31;
    return {8'((r << 3) | (r >> 2)), 8'((g << 2) | (g >> 4)), 8'((b << 3) | (b >> 2))};
  endfunction

  // Reference model: pixels come out in address order; reads issued minus
  // pixels accepted is the occupancy of pipeline plus FIFO.
  int          pix_idx, pix_total, outstanding, exp_addr;
  int          done_cnt = 0, rd_cnt = 0, cyc = 0, first_cyc, last_cyc;
  logic        prev_stall;
  logic [23:0] prev_data;
  logic        prev_sof, prev_eol, xfer;
  logic [23:0] got_q [$];

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      pix_idx = 0; pix_total = 0; outstanding = 0; exp_addr = 0; prev_stall = 1'b0;
    end else begin
      xfer = valid && ready && clk_en;
      if (prev_stall) begin
        chk("stall_valid", valid, 1'b1);
        chk("stall_data", data, prev_data);
        chk("stall_sof", sof, prev_sof);
        chk("stall_eol", eol, prev_eol);
      end
      if (!valid) chk("empty_outputs", {data, sof, eol}, 26'h0);
      if (!clk_en) chk("rd_en_gated", rd_en, 1'b0);
      if (rd_en) begin
        chk("rd_addr", rd_addr, exp_addr[AW-1:0]);
        exp_addr = (exp_addr + 1) % MEM;
        outstanding++;
        rd_cnt++;
      end
      if (xfer) begin
        chk("pix_data", data, ref_px(mem[pix_idx]));
        chk("pix_sof", sof, pix_idx == 0);
        chk("pix_eol", eol, (pix_idx % H) == H - 1);
        got_q.push_back(data);
        if (pix_total == 0) first_cyc = cyc;
        last_cyc = cyc;
        pix_idx = (pix_idx + 1) % MEM;
        pix_total++;
        outstanding--;
      end
      chk("occupancy", 32'(outstanding <= FD), 1);
      if (frame_done && clk_en) begin
        chk("done_pixels", pix_total, MEM);
        chk("done_outstanding", outstanding, 0);
        done_cnt++;
        pix_total = 0;
      end
      prev_stall = valid && !xfer;
      prev_data = data;
      prev_sof = sof;
      prev_eol = eol;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input int target, input int bound, input string name);
    int n;
    n = 0;
    while (done_cnt < target && n < bound) begin
      step();
      n++;
    end
    chk({name, "_done"}, 32'(done_cnt >= target), 1);
  endtask

  task automatic chk_zero(input string name);
    chk({name, "_outs"}, {rd_addr, rd_en, valid, sof, eol, busy, frame_done}, '0);
    chk({name, "_data"}, data, 24'h0);
  endtask

  typedef struct {
    logic [15:0] in;
    logic [23:0] exp;
  } vec_t;
  vec_t tbl [6];

  initial begin
    int lat, base, base_rd, n;
    tbl[0] = '{16'hFFFF, 24'hFFFFFF};
    tbl[1] = '{16'hF800, 24'hFF0000};
    tbl[2] = '{16'h07E0, 24'h00FF00};
    tbl[3] = '{16'h001F, 24'h0000FF};
    tbl[4] = '{16'h8410, 24'h848284};
    tbl[5] = '{16'h0000, 24'h000000};
    for (int a = 0; a < MEM; a++) mem[a] = 16'($urandom);
    for (int i = 0; i < 6; i++) mem[i] = tbl[i].in;

    repeat (3) step();
    chk_zero("reset");
    rst_n = 1'b1;
    step();
    chk_zero("idle");

    // full frame at full rate, conversion table, first-pixel latency
    got_q.delete();
    pulse_start();
    lat = 0;
    for (int k = 1; k <= 10; k++) begin
      step();
      if (valid) begin
        lat = k;
        break;
      end
    end
    chk("first_latency", lat, LAT + 1);
    chk("first_sof", sof, 1'b1);
    wait_done(1, 200, "frame1");
    for (int i = 0; i < 6; i++) chk($sformatf("conv_%0d", i), got_q[i], tbl[i].exp);
    chk("throughput", last_cyc - first_cyc, MEM - 1);
    repeat (3) step();
    chk("frame1_idle", busy, 1'b0);

    // random ready/enable, stray start pulses while busy
    for (int a = 0; a < MEM; a++) mem[a] = 16'($urandom);
    base = done_cnt;
    pulse_start();
    n = 0;
    while (done_cnt == base && n < 3000) begin
      ready  = 1'($urandom_range(0, 1));
      clk_en = ($urandom_range(0, 3) != 0);
      start  = busy && ($urandom_range(0, 7) == 0);
      step();
      n++;
    end
    start = 1'b0; clk_en = 1'b1; ready = 1'b1;
    chk("rand_done", done_cnt, base + 1);
    repeat (8) step();
    chk("rand_single_frame", done_cnt, base + 1);
    chk("rand_idle", busy, 1'b0);

    // backpressure: only FD reads may go out
    ready = 1'b0;
    base = done_cnt;
    base_rd = rd_cnt;
    pulse_start();
    repeat (30) step();
    chk("bp_reads", rd_cnt - base_rd, FD);
    chk("bp_rd_en", rd_en, 1'b0);
    chk("bp_valid", valid, 1'b1);
    ready = 1'b1;
    wait_done(base + 1, 200, "bp");

    // reset mid-frame with reads in flight
    base = done_cnt;
    pulse_start();
    n = 0;
    while (pix_total < 10 && n < 200) begin
      step();
      n++;
    end
    chk("mid_reached", 32'(pix_total >= 10), 1);
    chk("mid_inflight", 32'(outstanding > 0), 1);
    rst_n = 1'b0;
    step();
    chk_zero("mid_reset");
    rst_n = 1'b1;
    for (int k = 0; k < LAT + 2; k++) begin
      step();
      chk("stale_ignored", valid, 1'b0);
    end
    pulse_start();
    wait_done(base + 1, 200, "restart");
    chk("abort_no_done", done_cnt, base + 1);

    // start held high: back-to-back frames
    base = done_cnt;
    start = 1'b1;
    wait_done(base + 2, 400, "held");
    start = 1'b0;
    repeat (6) step();
    chk("held_count", done_cnt, base + 2);
    chk("held_idle", busy, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/rgb565_frame_reader.md
Name: rgb565_frame_reader

Overview:
- Read-side counterpart of the RGB888->RGB565 frame-buffer writer.
- On a start pulse, scans the RGB565 frame memory from address 0 to MEM_DEPTH-1 and expands each pixel to RGB888 by MSB replication.
- Streams pixels to the LCD/display path over a valid/ready interface, with start-of-frame and end-of-line markers.
- A small output FIFO absorbs the fixed memory read latency, so downstream backpressure never drops a pixel.

Parameters:
- H_ACTIVE, 480, pixels per line.
- V_ACTIVE, 272, lines per frame. Derived localparam MEM_DEPTH = H_ACTIVE*V_ACTIVE = 130560.
- ADDR_WIDTH, 17, read address width; must satisfy 2^ADDR_WIDTH >= MEM_DEPTH.
- RD_LAT, 1, memory read latency in enabled cycles (allowed range 1..3).
- FIFO_DEPTH, 4, output FIFO entries; must be >= RD_LAT+2.

Ports:
- iClk  in  1  clock.
- iRst_n  in  1  reset: synchronous, active-low.
- i_Clk_en  in  1  clock enable. When 0, all state is frozen, o_rd_en=0, and no handshake completes.
- i_start  in  1  frame start request; sampled only in IDLE.
- o_rd_addr  out  ADDR_WIDTH  frame memory read address.
- o_rd_en  out  1  read strobe; data returns on i_rd_data RD_LAT enabled cycles later.
- i_rd_data  in  16  RGB565 read data {R5,G6,B5}.
- o_data_rgb888  out  24  R[23:16], G[15:8], B[7:0].
- o_valid  out  1  output pixel valid (FIFO not empty).
- i_ready  in  1  downstream ready.
- o_sof  out  1  qualifies the current o_data word as pixel (0,0).
- o_eol  out  1  qualifies the current o_data word as the last pixel of a line (x == H_ACTIVE-1).
- o_busy  out  1  high in READ and DRAIN.
- o_frame_done  out  1  one enabled-cycle pulse after the last pixel is accepted.

Behaviour:
- Reset (iRst_n=0 at posedge): state=IDLE, addr=0, in-flight pipeline cleared, FIFO empty, output x/y=0. All outputs 0: o_rd_addr, o_rd_en, o_valid, o_sof, o_eol, o_busy, o_frame_done. o_data_rgb888 is 0 while FIFO is empty.
- Reset mid-frame aborts the frame. In-flight read data returning after reset is ignored because the latency valid shift register is cleared.
- FSM transitions (advance only when i_Clk_en=1):
  - IDLE: i_start=1 -> READ, addr=0.
  - READ: issues reads. Issuing address MEM_DEPTH-1 -> DRAIN.
  - DRAIN: no issue. Waits until in-flight=0 and the last pixel is popped -> DONE.
  - DONE: o_frame_done=1 for one cycle -> IDLE. addr is already back at 0.
- i_start outside IDLE is ignored; there is no restart mid-frame.
- Issue rule in READ: o_rd_en=1 iff i_Clk_en and (fifo_count + inflight_count) < FIFO_DEPTH, both taken from registered values with no same-cycle pop credit. Each issue increments addr.
- A length-RD_LAT valid shift register tracks in-flight reads. When its output is 1, i_rd_data is pushed into the FIFO. The credit rule guarantees no overflow; overflow is an assertion failure.
- Expansion (combinational at FIFO output or push; either is allowed):
  - R8={r5,r5[4:2]}
  - G8={g6,g6[5:4]}
  - B8={b5,b5[4:2]}
- Handshake: transfer occurs when o_valid & i_ready & i_Clk_en. o_data, o_sof and o_eol must stay stable while o_valid=1 and no transfer occurs.
- Output position counters x/y advance on each transfer:
  - x wraps at H_ACTIVE-1 and increments y.
  - y wraps at V_ACTIVE-1 to 0 at frame end.
  - o_sof = o_valid & x==0 & y==0.
  - o_eol = o_valid & x==H_ACTIVE-1.
- Throughput: with i_ready=1 and i_Clk_en=1, one pixel per cycle sustained after an initial latency of RD_LAT+1 cycles from i_start to first o_valid.
- Simultaneous push and pop on a full-minus-one or empty FIFO: the occupancy count is unchanged and the data ordering is preserved.
- The FIFO is first-word-fall-through, so o_valid reflects fifo_count != 0.

Test Plan:
- Memory model with RD_LAT=1 and mem[a]=a[15:0]; pulse i_start; i_ready=1 -> 130560 pixels in address order, the first at cycle 2 after start with o_sof=1, o_eol on every 480th pixel, o_frame_done pulses once, returns to IDLE.
- Conversion: mem words 0xFFFF, 0xF800, 0x07E0, 0x001F, 0x8410, 0x0000 -> 0xFFFFFF, 0xFF0000, 0x00FF00, 0x0000FF, 0x848284, 0x000000.
- Random i_ready (50%) and i_Clk_en (75%), RD_LAT=3, FIFO_DEPTH=5 -> no lost, duplicated or reordered pixels; o_data stable while stalled; fifo_count+inflight never exceeds 5.
- Hold i_ready=0 after start -> exactly FIFO_DEPTH reads issued, then o_rd_en stays 0. Release -> the stream resumes at the correct address.
- Assert reset at pixel 1000 with reads in flight -> next cycle all outputs 0 and FIFO empty. A new i_start restarts at address 0 with o_sof on the first pixel.
- Pulse i_start during READ and DRAIN -> ignored, exactly one frame emitted. i_start held high continuously -> back-to-back frames, with o_frame_done between them.
